btn_conditioner: RTL and testbench

Multi-channel push-button conditioner. Each channel synchronises a raw asynchronous button input, debounces it with a stable-count filter, and emits single-cycle event pulses on the selected edge(s). In rise mode it can also emit hold-to-repeat pulses. The block sits between the board buttons and the game control FSM, so cursor moves and stone placement each see exactly one clean strobe per press, or a timed stream while a key is held.

---
 rtl/btn_conditioner.sv | 123 ++++++++++++
 tb/tb_btn_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, stable-count debounce,
// edge event pulses and hold-to-repeat strobes, one independent lane per button.
module btn_conditioner #(
    parameter int N            = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CYCLES    = 1000000,
    parameter int EDGE_MODE    = 0,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] out,
    output logic         any_out
);
    localparam int CW   = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   out_q, out_d;
        logic                   s, upd, press_upd, rel_upd, edge_hit, rpt_pulse;
        rpt_state_e             state_q, state_d;
        logic [RW-1:0]          rcnt_q, rcnt_d;

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            upd     = 1'b0;
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                upd     = 1'b1;
                level_d = s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        assign press_upd = upd & s;
        assign rel_upd   = upd & ~s;
        assign edge_hit  = (EDGE_MODE == 0) ? press_upd :
                           (EDGE_MODE == 1) ? rel_upd : upd;

        // A release update or a dropped enable always wins over a due repeat pulse.
        always_comb begin
            state_d   = state_q;
            rcnt_d    = rcnt_q;
            rpt_pulse = 1'b0;
            if (EDGE_MODE != 0 || !repeat_en || rel_upd) begin
                state_d = IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (press_upd) begin
                            state_d = DELAY;
                            rcnt_d  = RW'(1);
                        end
                    end
                    DELAY: begin
                        if (rcnt_q == RW'(REPEAT_DELAY)) begin
                            rpt_pulse = 1'b1;
                            rcnt_d    = RW'(1);
                            state_d   = REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q == RW'(REPEAT_RATE)) begin
                            rpt_pulse = 1'b1;
                            rcnt_d    = RW'(1);
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        assign out_d = edge_hit | rpt_pulse;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                out_q   <= 1'b0;
                rcnt_q  <= '0;
                state_q <= IDLE;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], in[i]};
                cnt_q   <= cnt_d;
                level_q <= level_d;
                out_q   <= out_d;
                rcnt_q  <= rcnt_d;
                state_q <= state_d;
            end
        end

        assign level[i] = level_q;
        assign out[i]   = out_q;
    end

    assign any_out = |out;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: rise-mode and both-edge instances driven together,
// compared every cycle against a window-based behavioural model.
module tb_btn_conditioner;
    localparam int N  = 2;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         repeat_en = 1'b0;
    logic [N-1:0] in_r = '0;
    logic [N-1:0] lvl_a, out_a, lvl_b, out_b;
    logic         any_a, any_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N(N), .SYNC_STAGES(SS), .DB_CYCLES(DB), .EDGE_MODE(0),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_dut (
        .clk(clk), .rst(rst), .in(in_r), .repeat_en(repeat_en),
        .level(lvl_a), .out(out_a), .any_out(any_a)
    );

    btn_conditioner #(
        .N(N), .SYNC_STAGES(SS), .DB_CYCLES(DB), .EDGE_MODE(2),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_dut_both (
        .clk(clk), .rst(rst), .in(in_r), .repeat_en(repeat_en),
        .level(lvl_b), .out(out_b), .any_out(any_b)
    );

    // Model: s is a pure delay of the input; a level change is accepted once the
    // last DB synchronised samples all disagree with the current level.
    logic [N-1:0] m_sync [SS];
    logic [N-1:0] s_hist [DB];
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_out [2];
    bit           armed [N];
    int           tp [N];
    int           cyc = 0;

    task automatic model_step();
        logic [N-1:0] s_prev;
        bit           upd, press, rel, rp;
        if (rst) begin
            for (int j = 0; j < SS; j++) m_sync[j] = '0;
            for (int j = 0; j < DB; j++) s_hist[j] = '0;
            m_lvl    = '0;
            m_out[0] = '0;
            m_out[1] = '0;
            for (int ch = 0; ch < N; ch++) armed[ch] = 1'b0;
            return;
        end
        cyc++;
        s_prev = s_hist[0];
        for (int ch = 0; ch < N; ch++) begin
            upd = 1'b1;
            for (int k = 0; k < DB; k++)
                if (s_hist[k][ch] == m_lvl[ch]) upd = 1'b0;
            press = upd && s_prev[ch];
            rel   = upd && !s_prev[ch];
            rp    = 1'b0;
            if (!repeat_en || rel) armed[ch] = 1'b0;
            else if (armed[ch]) begin
                if ((cyc - tp[ch]) >= RD && ((cyc - tp[ch] - RD) % RR) == 0) rp = 1'b1;
            end else if (press) begin
                armed[ch] = 1'b1;
                tp[ch]    = cyc;
            end
            m_out[0][ch] = press | rp;
            m_out[1][ch] = upd;
            if (upd) m_lvl[ch] = s_prev[ch];
        end
        for (int k = DB - 1; k > 0; k--) s_hist[k] = s_hist[k-1];
        for (int j = SS - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
        m_sync[0] = in_r;
        s_hist[0] = m_sync[SS-1];
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("level",      lvl_a, m_lvl);
        check("out",        out_a, m_out[0]);
        check("any_out",    any_a, |m_out[0]);
        check("level_both", lvl_b, m_lvl);
        check("out_both",   out_b, m_out[1]);
        check("any_both",   any_b, |m_out[1]);
    endtask

    int cnt_a, cnt_b;

    initial begin
        step();
        step();
        check("rst_level", lvl_a, 0);
        check("rst_out",   out_a, 0);
        rst = 1'b0;
        repeat (3) step();

        // clean press
        in_r = 2'b01;
        for (int e = 0; e < 8; e++) begin
            step();
            if (e == 4) check("press_early", lvl_a, 2'b00);
            if (e == 5) begin
                check("press_out5", out_a, 2'b01);
                check("press_lvl5", lvl_a, 2'b01);
            end
            if (e == 6) check("press_out6", out_a, 2'b00);
        end
        in_r = 2'b00;
        repeat (10) step();

        // bounce rejection
        for (int e = 0; e < 23; e++) begin
            in_r[0] = (e < 3) || (e >= 5 && e < 8);
            step();
            check("bounce_lvl", lvl_a[0], 1'b0);
            check("bounce_out", out_a[0], 1'b0);
        end

        // auto-repeat, then release
        repeat_en = 1'b1;
        in_r = 2'b01;
        cnt_a = 0;
        for (int e = 0; e < 55; e++) begin
            if (e == 40) in_r = 2'b00;
            step();
            cnt_a += int'(out_a[0]);
        end
        check("repeat_count", cnt_a, 11);

        // hold with repeat disabled
        repeat_en = 1'b0;
        in_r = 2'b01;
        cnt_a = 0;
        cnt_b = 0;
        for (int e = 0; e < 45; e++) begin
            if (e == 30) in_r = 2'b00;
            step();
            cnt_a += int'(out_a[0]);
            cnt_b += int'(out_b[0]);
        end
        check("norepeat_count", cnt_a, 1);
        check("both_edge_count", cnt_b, 2);

        // reset mid-hold
        in_r = 2'b01;
        repeat (8) step();
        rst = 1'b1;
        step();
        check("midrst_lvl", lvl_a, 0);
        check("midrst_out", out_a, 0);
        check("midrst_any", any_a, 0);
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            if (e == 4) check("midrst_out4", out_a[0], 1'b0);
            if (e == 5) check("midrst_out5", out_a[0], 1'b1);
        end
        in_r = 2'b00;
        repeat (10) step();

        // simultaneous channels
        in_r = 2'b11;
        for (int e = 0; e < 8; e++) begin
            step();
            if (e == 5) begin
                check("simul_out", out_a, 2'b11);
                check("simul_any", any_a, 1'b1);
            end
            if (e == 6) check("simul_any6", any_a, 1'b0);
        end
        in_r = 2'b00;
        repeat (10) step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) repeat_en = ~repeat_en;
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, (c < 1500) ? 11 : 39) == 0) in_r[ch] = ~in_r[ch];
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
